pea_token_writer: RTL and testbench

- Host-side producer for the PEA input FIFOs; the writer end of the protocol the PEA top level reads.
- Accepts one command request with valid/ready, packs it into a 16-bit control token, and streams its coefficient/data words.
- Writes the control token into the Control Input FIFO and its N data words into the Data Input FIFO.
- A command is issued only when both FIFOs have room for the whole command, so the PEA never pops a control token whose data is not yet present.

---
 rtl/pea_pkg.sv | 34 +++
 rtl/pea_token_writer.sv | 145 ++++++++++++++
 tb/tb_pea_token_writer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pea_pkg.sv
// Shared definitions for the PEA host interface: token field layout, opcodes,
// writer FSM states and a constant log2 helper for sizing free-space ports.
package pea_pkg;

    localparam int CMD_MSB  = 15;
    localparam int CMD_LSB  = 8;
    localparam int ARG1_MSB = 7;
    localparam int ARG1_LSB = 5;
    localparam int ARG2_MSB = 4;
    localparam int ARG2_LSB = 0;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_LOAD_COEF = 8'h01;
    localparam logic [7:0] OP_LOAD_DATA = 8'h02;
    localparam logic [7:0] OP_RUN       = 8'h03;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        WR_CTRL,
        WR_DATA
    } wr_state_t;

    // Ceiling log2; a 1024-word FIFO yields a 10-bit free-space count.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pea_token_writer.sv
// Host-side writer for the PEA input FIFOs: packs one request into a control
// token and streams its data words, only once both FIFOs can hold the command.
module pea_token_writer
    import pea_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int BUFFER_SIZE = 1024,
    parameter int MAX_DATA    = 32,
    localparam int FS_W       = log2(BUFFER_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           req_cmd,
    input  logic [2:0]           req_arg1,
    input  logic [4:0]           req_arg2,
    input  logic [5:0]           req_ndata,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [WORD_SIZE-1:0] src_data,
    input  logic [FS_W-1:0]      control_free_space,
    input  logic [FS_W-1:0]      data_free_space,
    output logic                 control_wr_en,
    output logic [WORD_SIZE-1:0] control_out,
    output logic                 data_wr_en,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 done,
    output logic                 err
);

    wr_state_t            state, state_nxt;
    logic [7:0]           cmd_q, cmd_d;
    logic [2:0]           arg1_q, arg1_d;
    logic [4:0]           arg2_q, arg2_d;
    logic [5:0]           ndata_q, ndata_d;
    logic [5:0]           remaining_q, remaining_d;
    logic                 control_wr_en_d, data_wr_en_d, done_d, err_d;
    logic [WORD_SIZE-1:0] control_out_d, data_out_d;
    logic [WORD_SIZE-1:0] token;

    always_comb begin
        token                     = '0;
        token[CMD_MSB:CMD_LSB]    = cmd_q;
        token[ARG1_MSB:ARG1_LSB]  = arg1_q;
        token[ARG2_MSB:ARG2_LSB]  = arg2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cmd_q         <= '0;
            arg1_q        <= '0;
            arg2_q        <= '0;
            ndata_q       <= '0;
            remaining_q   <= '0;
            control_wr_en <= 1'b0;
            control_out   <= '0;
            data_wr_en    <= 1'b0;
            data_out      <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_nxt;
            cmd_q         <= cmd_d;
            arg1_q        <= arg1_d;
            arg2_q        <= arg2_d;
            ndata_q       <= ndata_d;
            remaining_q   <= remaining_d;
            control_wr_en <= control_wr_en_d;
            control_out   <= control_out_d;
            data_wr_en    <= data_wr_en_d;
            data_out      <= data_out_d;
            done          <= done_d;
            err           <= err_d;
        end
    end

    // Space is checked once for the whole command; as sole writer we never
    // see it shrink, so per-word rechecks are unnecessary.
    always_comb begin
        state_nxt       = state;
        cmd_d           = cmd_q;
        arg1_d          = arg1_q;
        arg2_d          = arg2_q;
        ndata_d         = ndata_q;
        remaining_d     = remaining_q;
        control_wr_en_d = 1'b0;
        control_out_d   = control_out;
        data_wr_en_d    = 1'b0;
        data_out_d      = data_out;
        done_d          = 1'b0;
        err_d           = 1'b0;
        req_ready       = 1'b0;
        src_ready       = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cmd_d   = req_cmd;
                    arg1_d  = req_arg1;
                    arg2_d  = req_arg2;
                    ndata_d = req_ndata;
                    if (int'(req_ndata) > MAX_DATA) begin
                        err_d = 1'b1;
                    end else begin
                        state_nxt = WAIT_SPACE;
                    end
                end
            end
            WAIT_SPACE: begin
                if ((control_free_space != '0) &&
                    (int'(data_free_space) >= int'(ndata_q))) begin
                    state_nxt = WR_CTRL;
                end
            end
            WR_CTRL: begin
                control_wr_en_d = 1'b1;
                control_out_d   = token;
                if (ndata_q == 6'd0) begin
                    done_d    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    remaining_d = ndata_q;
                    state_nxt   = WR_DATA;
                end
            end
            WR_DATA: begin
                src_ready = 1'b1;
                if (src_valid) begin
                    data_wr_en_d = 1'b1;
                    data_out_d   = src_data;
                    remaining_d  = remaining_q - 6'd1;
                    if (remaining_q == 6'd1) begin
                        done_d    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pea_token_writer.sv
// Self-checking bench for pea_token_writer: logs FIFO writes per cycle and
// compares them with tokens/words/timing predicted from the protocol rules.
module tb_pea_token_writer;
    import pea_pkg::*;

    localparam int WS   = 16;
    localparam int FS_W = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [7:0]    req_cmd = '0;
    logic [2:0]    req_arg1 = '0;
    logic [4:0]    req_arg2 = '0;
    logic [5:0]    req_ndata = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [WS-1:0] src_data = '0;
    logic [FS_W-1:0] control_free_space = 10'd1023;
    logic [FS_W-1:0] data_free_space = 10'd1023;
    logic          control_wr_en;
    logic [WS-1:0] control_out;
    logic          data_wr_en;
    logic [WS-1:0] data_out;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] ctrl_log[$];
    int          ctrl_cyc[$];
    logic [15:0] data_log[$];
    int          data_cyc[$];
    int          done_log[$];
    int          err_log[$];
    logic [15:0] no_words[$];
    bit          no_pat[$];

    pea_token_writer #(.WORD_SIZE(WS), .BUFFER_SIZE(1024), .MAX_DATA(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_arg1(req_arg1), .req_arg2(req_arg2), .req_ndata(req_ndata),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .control_free_space(control_free_space), .data_free_space(data_free_space),
        .control_wr_en(control_wr_en), .control_out(control_out),
        .data_wr_en(data_wr_en), .data_out(data_out),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed FIFO traffic, stamped with the number of rising edges so far.
    always @(negedge clk) begin
        if (control_wr_en === 1'b1) begin ctrl_log.push_back(control_out); ctrl_cyc.push_back(cyc); end
        if (data_wr_en === 1'b1) begin data_log.push_back(data_out); data_cyc.push_back(cyc); end
        if (done === 1'b1) done_log.push_back(cyc);
        if (err === 1'b1) err_log.push_back(cyc);
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log;
        ctrl_log.delete(); ctrl_cyc.delete();
        data_log.delete(); data_cyc.delete();
        done_log.delete(); err_log.delete();
    endtask

    task automatic issue_req(input logic [7:0] c, input logic [2:0] a1, input logic [4:0] a2,
                             input logic [5:0] nd, output int acc_cyc);
        int budget;
        budget = 50;
        tick;
        while (req_ready !== 1'b1 && budget > 0) begin tick; budget--; end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req_ready_before_issue: got %b, want 1", req_ready);
        end
        req_valid = 1'b1; req_cmd = c; req_arg1 = a1; req_arg2 = a2; req_ndata = nd;
        acc_cyc = cyc;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic [7:0] c, input logic [2:0] a1,
                           input logic [4:0] a2, input logic [5:0] nd,
                           input logic [15:0] words_in[$], input bit pat[$], input int gap_pct,
                           input int stall_cycles, input int stall_space);
        logic [15:0] words[$];
        int hs_cyc[$];
        int acc, exp_ctrl_cyc, exp_done_cyc, idx, step, budget, tok, n;
        bit v;
        n = int'(nd);
        idx = 0; step = 0; budget = 400;
        clear_log();
        words = words_in;
        while (words.size() < n) words.push_back(16'($urandom));
        tok = (int'(c) << 8) + (int'(a1) << 5) + int'(a2);
        data_free_space = (stall_cycles > 0) ? 10'(stall_space) : 10'd1023;
        issue_req(c, a1, a2, nd, acc);
        exp_ctrl_cyc = acc + 3;
        if (stall_cycles > 0) begin
            repeat (stall_cycles) tick;
            checks++;
            if (ctrl_log.size() != 0 || data_log.size() != 0) begin
                errors++;
                $display("[TB] FAIL %s stall_no_write: got %0d ctrl/%0d data writes, want 0/0",
                         name, ctrl_log.size(), data_log.size());
            end
            data_free_space = 10'(n);
            exp_ctrl_cyc = cyc + 2;
        end
        while (done_log.size() == 0 && budget > 0) begin
            if (pat.size() > 0) v = (step < pat.size()) ? pat[step] : 1'b1;
            else v = ($urandom_range(99) >= gap_pct);
            src_valid = v && (idx < n);
            src_data = (idx < n) ? words[idx] : 16'($urandom);
            if (src_ready === 1'b1) begin
                step++;
                if (src_valid) begin hs_cyc.push_back(cyc); idx++; end
            end
            tick;
            budget--;
        end
        src_valid = 1'b0;
        checks++;
        if (done_log.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s done_timeout: got no done, want done within 400 cycles", name);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s req_ready_after_done: got %b, want 1", name, req_ready);
        end
        tick;
        checks++;
        if (ctrl_log.size() != 1) begin
            errors++;
            $display("[TB] FAIL %s ctrl_count: got %0d, want 1", name, ctrl_log.size());
        end else begin
            checks++;
            if (ctrl_log[0] !== 16'(tok)) begin
                errors++;
                $display("[TB] FAIL %s ctrl_token: got %h, want %h", name, ctrl_log[0], 16'(tok));
            end
            checks++;
            if (ctrl_cyc[0] != exp_ctrl_cyc) begin
                errors++;
                $display("[TB] FAIL %s ctrl_cycle: got %0d, want %0d", name, ctrl_cyc[0], exp_ctrl_cyc);
            end
        end
        checks++;
        if (data_log.size() != n) begin
            errors++;
            $display("[TB] FAIL %s data_count: got %0d, want %0d", name, data_log.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (data_log[i] !== words[i] || data_cyc[i] != hs_cyc[i] + 1) begin
                    errors++;
                    $display("[TB] FAIL %s data_word%0d: got %h@%0d, want %h@%0d",
                             name, i, data_log[i], data_cyc[i], words[i], hs_cyc[i] + 1);
                end
            end
            if (n > 0 && ctrl_cyc.size() > 0) begin
                checks++;
                if (data_cyc[0] <= ctrl_cyc[0]) begin
                    errors++;
                    $display("[TB] FAIL %s data_before_ctrl: got data@%0d, want after ctrl@%0d",
                             name, data_cyc[0], ctrl_cyc[0]);
                end
            end
        end
        exp_done_cyc = (n == 0 || hs_cyc.size() == 0) ? exp_ctrl_cyc : hs_cyc[hs_cyc.size() - 1] + 1;
        checks++;
        if (done_log.size() != 1 || done_log[0] != exp_done_cyc) begin
            errors++;
            $display("[TB] FAIL %s done_pulse: got %0d pulses first@%0d, want 1@%0d", name,
                     done_log.size(), (done_log.size() > 0) ? done_log[0] : -1, exp_done_cyc);
        end
        checks++;
        if (err_log.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s unexpected_err: got %0d pulses, want 0", name, err_log.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        repeat (3) tick;
        checks++;
        if ({control_wr_en, control_out, data_wr_en, data_out, done, err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got wr=%b ctrl=%h dwr=%b data=%h done=%b err=%b, want all 0",
                     control_wr_en, control_out, data_wr_en, data_out, done, err);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (req_ready !== 1'b1 || src_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got req_ready=%b src_ready=%b, want 1/0", req_ready, src_ready);
        end
        clear_log();
        repeat (20) tick;
        checks++;
        if (ctrl_log.size() != 0 || data_log.size() != 0 || done_log.size() != 0) begin
            errors++;
            $display("[TB] FAIL idle_quiet: got %0d ctrl %0d data %0d done, want none",
                     ctrl_log.size(), data_log.size(), done_log.size());
        end
    endtask

    task automatic test_basic;
        logic [15:0] w[$];
        w.push_back(16'h0001); w.push_back(16'hFFFE); w.push_back(16'h7FFF);
        run_cmd("basic", OP_RUN, 3'd2, 5'd5, 6'd3, w, no_pat, 0, 0, 0);
    endtask

    task automatic test_space_stall;
        run_cmd("stall", OP_LOAD_COEF, 3'd1, 5'd17, 6'd4, no_words, no_pat, 0, 8, 2);
    endtask

    task automatic test_zero_data;
        run_cmd("zero_data", OP_NOP, 3'd7, 5'd31, 6'd0, no_words, no_pat, 0, 0, 0);
    endtask

    task automatic test_reject(input logic [5:0] nd);
        int acc;
        clear_log();
        data_free_space = 10'd1023;
        issue_req(OP_LOAD_DATA, 3'd3, 5'd9, nd, acc);
        repeat (10) tick;
        checks++;
        if (err_log.size() != 1 || err_log[0] != acc + 1) begin
            errors++;
            $display("[TB] FAIL reject_err ndata=%0d: got %0d pulses first@%0d, want 1@%0d", nd,
                     err_log.size(), (err_log.size() > 0) ? err_log[0] : -1, acc + 1);
        end
        checks++;
        if (ctrl_log.size() != 0 || data_log.size() != 0 || done_log.size() != 0 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reject_quiet ndata=%0d: got %0d ctrl %0d data %0d done ready=%b, want 0/0/0/1",
                     nd, ctrl_log.size(), data_log.size(), done_log.size(), req_ready);
        end
    endtask

    task automatic test_source_gaps;
        bit p[$];
        p.push_back(1'b1); p.push_back(1'b0); p.push_back(1'b0); p.push_back(1'b1); p.push_back(1'b1);
        run_cmd("src_gaps", OP_LOAD_DATA, 3'd0, 5'd1, 6'd3, no_words, p, 0, 0, 0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            run_cmd("random", 8'($urandom), 3'($urandom), 5'($urandom),
                    6'($urandom_range(0, 32)), no_words, no_pat, 30, 0, 0);
        end
        run_cmd("max_data", OP_LOAD_COEF, 3'd4, 5'd20, 6'd32, no_words, no_pat, 0, 0, 0);
        test_reject(6'($urandom_range(34, 63)));
    endtask

    task automatic test_mid_reset;
        int acc, budget;
        clear_log();
        data_free_space = 10'd1023;
        issue_req(OP_RUN, 3'd5, 5'd12, 6'd5, acc);
        budget = 50;
        src_valid = 1'b1;
        while (data_log.size() < 2 && budget > 0) begin
            src_data = 16'($urandom);
            tick;
            budget--;
        end
        checks++;
        if (data_log.size() < 2) begin
            errors++;
            $display("[TB] FAIL mid_reset_setup: got %0d data writes, want 2", data_log.size());
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({control_wr_en, control_out, data_wr_en, data_out, done, err} !== '0 ||
            req_ready !== 1'b1 || src_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got dwr=%b data=%h ctrl=%h req_ready=%b src_ready=%b, want 0/0/0/1/0",
                     data_wr_en, data_out, control_out, req_ready, src_ready);
        end
        repeat (3) tick;
        rst = 1'b0;
        repeat (6) tick;
        src_valid = 1'b0;
        checks++;
        if (data_log.size() != 2 || ctrl_log.size() != 1 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_stop: got %0d data %0d ctrl ready=%b, want 2/1/1",
                     data_log.size(), ctrl_log.size(), req_ready);
        end
        run_cmd("after_reset", OP_RUN, 3'd1, 5'd2, 6'd2, no_words, no_pat, 20, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_space_stall();
        test_zero_data();
        test_reject(6'd33);
        test_source_gaps();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
